// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch/execute sequencer.
package fetch_sequencer_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        FETCH1 = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        COMMIT = 3'd4,
        HALT   = 3'd5
    } state_e;

    // States that own the memory bus.
    function automatic logic is_bus_state(input state_e s);
        return (s == FETCH0) || (s == FETCH1) || (s == EXEC);
    endfunction

endpackage

// File: rtl/fetch_sequencer_bus_wait_timer.sv
// Bus wait counter with expiry detect.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the counter (no access waiting)
//   enable     : access waiting this cycle (req high, ready low)
//   expire_c   : this waiting cycle is the BUS_TIMEOUT-th; 0 when BUS_TIMEOUT==0
module fetch_sequencer_bus_wait_timer #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST =
        CNT_W'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Counts waited cycles of the current access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Expiry only on a cycle that is still waiting, so a ready in that cycle wins.
    assign expire_c = (BUS_TIMEOUT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: owns the PC, fetches 1-2 instruction
// bytes, performs the optional data access and commits the next PC.
//   pc, instr, longoffs      : architectural PC and latched instruction bytes
//   dec_*                    : decoder results for instr
//   calc_addr, calc_pcout    : address calculator results
//   bus_*                    : single 8-bit memory bus (req held until ready)
//   retire, halted, fault    : commit pulse and stop status
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc,
    output logic [7:0]  instr,
    output logic [7:0]  longoffs,
    input  logic        dec_twobyte,
    input  logic        dec_mem,
    input  logic        dec_write,
    input  logic        dec_halt,
    input  logic [15:0] calc_addr,
    input  logic [15:0] calc_pcout,
    output logic [15:0] bus_addr,
    output logic        bus_req,
    output logic        bus_we,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ready,
    output logic        retire,
    output logic        halted,
    output logic        fault
);

    state_e            state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [DATA_W-1:0] instr_n, longoffs_n;
    logic              fault_n;
    logic              done_c, wait_c, expire_c;

    // A ready with no request pending is ignored.
    assign done_c = bus_req && bus_ready;
    assign wait_c = bus_req && !bus_ready;

    fetch_sequencer_bus_wait_timer #(
        .BUS_TIMEOUT(BUS_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!wait_c),
        .enable  (wait_c),
        .expire_c(expire_c)
    );

    // Address mux; calc_addr is only stable once instr/longoffs are latched,
    // so the data address is not registered.
    always_comb begin
        bus_addr = pc;
        if (state == EXEC) begin
            bus_addr = calc_addr;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = instr;
        longoffs_n = longoffs;
        fault_n    = fault;
        unique case (state)
            FETCH0: begin
                if (done_c) begin
                    instr_n    = bus_rdata;
                    longoffs_n = '0;
                    state_n    = DECODE;
                end else if (expire_c) begin
                    fault_n = 1'b1;
                    state_n = HALT;
                end
            end
            DECODE: begin
                if (dec_halt) begin
                    state_n = HALT;
                end else if (dec_twobyte) begin
                    pc_n    = pc + ADDR_W'(1);
                    state_n = FETCH1;
                end else if (dec_mem) begin
                    state_n = EXEC;
                end else begin
                    state_n = COMMIT;
                end
            end
            FETCH1: begin
                if (done_c) begin
                    longoffs_n = bus_rdata;
                    state_n    = dec_mem ? EXEC : COMMIT;
                end else if (expire_c) begin
                    fault_n = 1'b1;
                    state_n = HALT;
                end
            end
            EXEC: begin
                if (done_c) begin
                    state_n = COMMIT;
                end else if (expire_c) begin
                    fault_n = 1'b1;
                    state_n = HALT;
                end
            end
            COMMIT: begin
                pc_n    = calc_pcout;
                state_n = FETCH0;
            end
            HALT: begin
                state_n = HALT;
            end
            default: begin
                state_n = FETCH0;
            end
        endcase
    end

    // State and registered outputs; bus outputs are decoded from the next
    // state so they are valid for the whole cycle of that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH0;
            pc       <= RESET_PC;
            instr    <= '0;
            longoffs <= '0;
            bus_req  <= 1'b0;
            bus_we   <= 1'b0;
            retire   <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            instr    <= instr_n;
            longoffs <= longoffs_n;
            bus_req  <= is_bus_state(state_n);
            bus_we   <= (state_n == EXEC) && dec_write;
            retire   <= (state_n == COMMIT);
            halted   <= (state_n == HALT);
            fault    <= fault_n;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; the bench plays decoder, address
// calculator and memory. Outputs are sampled 1 time unit after posedge.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic [7:0]  instr;
    logic [7:0]  longoffs;
    logic        dec_twobyte, dec_mem, dec_write, dec_halt;
    logic [15:0] calc_addr, calc_pcout;
    logic [15:0] bus_addr;
    logic        bus_req, bus_we;
    logic [7:0]  bus_rdata;
    logic        bus_ready;
    logic        retire, halted, fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC   (16'h0000),
        .BUS_TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .instr      (instr),
        .longoffs   (longoffs),
        .dec_twobyte(dec_twobyte),
        .dec_mem    (dec_mem),
        .dec_write  (dec_write),
        .dec_halt   (dec_halt),
        .calc_addr  (calc_addr),
        .calc_pcout (calc_pcout),
        .bus_addr   (bus_addr),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready),
        .retire     (retire),
        .halted     (halted),
        .fault      (fault)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic tb, input logic m, input logic w, input logic h);
        dec_twobyte = tb;
        dec_mem     = m;
        dec_write   = w;
        dec_halt    = h;
    endtask

    // One-byte non-memory instruction from FETCH0 with bus_req already high.
    task automatic run_short(input logic [7:0] op, input logic [15:0] npc);
        set_dec(1'b0, 1'b0, 1'b0, 1'b0);
        bus_rdata  = op;
        bus_ready  = 1'b1;
        calc_pcout = npc;
        step();
        bus_ready = 1'b0;
        step();
        check("short_retire", 16'(retire), 16'h1);
        step();
        check("short_pc", pc, npc);
    endtask

    initial begin
        rst_n      = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0);
        calc_addr  = 16'h0000;
        calc_pcout = 16'h0000;
        bus_rdata  = 8'h00;
        bus_ready  = 1'b0;
        #2;
        check("rst_pc", pc, 16'h0000);
        check("rst_instr", 16'(instr), 16'h0);
        check("rst_longoffs", 16'(longoffs), 16'h0);
        check("rst_bus_req", 16'(bus_req), 16'h0);
        check("rst_bus_we", 16'(bus_we), 16'h0);
        check("rst_retire", 16'(retire), 16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        check("rst_fault", 16'(fault), 16'h0);
        step();
        rst_n = 1'b1;
        step();

        // 1-byte non-mem at 0000, zero-wait: FETCH0, DECODE, COMMIT.
        check("t1_req", 16'(bus_req), 16'h1);
        check("t1_addr", bus_addr, 16'h0000);
        check("t1_we", 16'(bus_we), 16'h0);
        bus_rdata  = 8'h11;
        bus_ready  = 1'b1;
        calc_pcout = 16'h0001;
        step();
        check("t1_instr", 16'(instr), 16'h0011);
        check("t1_decode_noreq", 16'(bus_req), 16'h0);
        check("t1_decode_noretire", 16'(retire), 16'h0);
        bus_ready = 1'b0;
        step();
        check("t1_retire", 16'(retire), 16'h1);
        check("t1_pc_before", pc, 16'h0000);
        step();
        check("t1_pc", pc, 16'h0001);
        check("t1_retire_end", 16'(retire), 16'h0);
        check("t1_next_addr", bus_addr, 16'h0001);

        run_short(8'h12, 16'h0010);

        // 2-byte jump at 0010, second byte F0; ready held high through DECODE.
        set_dec(1'b1, 1'b0, 1'b0, 1'b0);
        bus_rdata  = 8'h80;
        bus_ready  = 1'b1;
        calc_pcout = 16'h0005;
        step();
        check("t2_instr", 16'(instr), 16'h0080);
        check("t2_longoffs_clr", 16'(longoffs), 16'h0000);
        check("t2_decode_noreq", 16'(bus_req), 16'h0);
        step();
        check("t2_f1_req", 16'(bus_req), 16'h1);
        check("t2_f1_pc", pc, 16'h0011);
        check("t2_f1_addr", bus_addr, 16'h0011);
        bus_rdata = 8'hF0;
        step();
        check("t2_longoffs", 16'(longoffs), 16'h00F0);
        check("t2_retire", 16'(retire), 16'h1);
        check("t2_pc_last_byte", pc, 16'h0011);
        bus_ready = 1'b0;
        step();
        check("t2_pc", pc, 16'h0005);

        run_short(8'h13, 16'h0020);

        // Store at 0020 to FF3A, ready on the 4th request cycle (expiry cycle).
        set_dec(1'b0, 1'b1, 1'b1, 1'b0);
        calc_addr  = 16'hFF3A;
        calc_pcout = 16'h0021;
        bus_rdata  = 8'h40;
        bus_ready  = 1'b1;
        step();
        bus_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            check("t3_req", 16'(bus_req), 16'h1);
            check("t3_we", 16'(bus_we), 16'h1);
            check("t3_addr", bus_addr, 16'hFF3A);
            if (i == 3) bus_ready = 1'b1;
        end
        step();
        check("t3_retire", 16'(retire), 16'h1);
        check("t3_commit_noreq", 16'(bus_req), 16'h0);
        check("t3_commit_nowe", 16'(bus_we), 16'h0);
        check("t3_ready_wins", 16'(halted), 16'h0);
        check("t3_pc_hold", pc, 16'h0020);
        bus_ready = 1'b0;
        step();
        check("t3_pc", pc, 16'h0021);

        run_short(8'h14, 16'hFFFF);

        // 2-byte non-mem at FFFF: second byte fetched from 0000.
        set_dec(1'b1, 1'b0, 1'b0, 1'b0);
        calc_pcout = 16'h0030;
        bus_rdata  = 8'h81;
        bus_ready  = 1'b1;
        step();
        step();
        check("t4_wrap_pc", pc, 16'h0000);
        check("t4_wrap_addr", bus_addr, 16'h0000);
        bus_rdata = 8'h07;
        step();
        check("t4_longoffs", 16'(longoffs), 16'h0007);
        check("t4_retire", 16'(retire), 16'h1);
        step();
        check("t4_pc", pc, 16'h0030);

        // 2-byte load at 0030, zero-wait: 5 cycles.
        set_dec(1'b1, 1'b1, 1'b0, 1'b0);
        calc_addr  = 16'h1234;
        calc_pcout = 16'h0040;
        bus_rdata  = 8'hC3;
        bus_ready  = 1'b1;
        step();
        check("t5_instr", 16'(instr), 16'h00C3);
        bus_rdata = 8'h5A;
        step();
        check("t5_f1_addr", bus_addr, 16'h0031);
        step();
        check("t5_longoffs", 16'(longoffs), 16'h005A);
        check("t5_exec_addr", bus_addr, 16'h1234);
        check("t5_exec_req", 16'(bus_req), 16'h1);
        check("t5_exec_we", 16'(bus_we), 16'h0);
        step();
        check("t5_retire", 16'(retire), 16'h1);
        step();
        check("t5_pc", pc, 16'h0040);
        check("t5_retire_end", 16'(retire), 16'h0);

        // Halt instruction; ready kept high to show it is ignored.
        set_dec(1'b0, 1'b0, 1'b0, 1'b1);
        bus_rdata = 8'hFF;
        step();
        step();
        check("t6_halted", 16'(halted), 16'h1);
        check("t6_nofault", 16'(fault), 16'h0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t6_noreq", 16'(bus_req), 16'h0);
            check("t6_noretire", 16'(retire), 16'h0);
            check("t6_pc_hold", pc, 16'h0040);
        end
        bus_ready = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset exits HALT.
        rst_n = 1'b0;
        #1;
        check("t7_halt_rst", 16'(halted), 16'h0);
        check("t7_pc_rst", pc, 16'h0000);
        step();
        rst_n = 1'b1;
        step();
        check("t7_req", 16'(bus_req), 16'h1);

        // Reset pulse in the middle of EXEC.
        set_dec(1'b0, 1'b1, 1'b1, 1'b0);
        calc_addr = 16'h0100;
        bus_rdata = 8'h50;
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        step();
        check("t7_exec_we", 16'(bus_we), 16'h1);
        check("t7_exec_addr", bus_addr, 16'h0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_mid_req", 16'(bus_req), 16'h0);
        check("t7_mid_we", 16'(bus_we), 16'h0);
        check("t7_mid_pc", pc, 16'h0000);
        check("t7_mid_instr", 16'(instr), 16'h0);
        step();
        rst_n = 1'b1;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("t7_restart_req", 16'(bus_req), 16'h1);
        check("t7_restart_addr", bus_addr, 16'h0000);

        // Timeout: no ready in FETCH0, BUS_TIMEOUT=4 wait cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check("t8_not_yet", 16'(halted), 16'h0);
            check("t8_noretire", 16'(retire), 16'h0);
        end
        step();
        check("t8_halted", 16'(halted), 16'h1);
        check("t8_fault", 16'(fault), 16'h1);
        check("t8_pc", pc, 16'h0000);
        check("t8_noreq", 16'(bus_req), 16'h0);
        check("t8_noretire_end", 16'(retire), 16'h0);
        rst_n = 1'b0;
        #1;
        check("t8_fault_clr", 16'(fault), 16'h0);
        check("t8_halt_clr", 16'(halted), 16'h0);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch/execute sequencer. Owns the architectural PC register and drives it into the combinational address calculator. Consumes the calculator's data address and next-PC results. Arbitrates a single 8-bit memory bus between instruction fetch (1 or 2 bytes) and the data access. Commits the next PC once per instruction.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
BUS_TIMEOUT, 255, maximum bus_ready wait cycles per access; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc  out  16  current PC; feeds address calculator pcin
instr  out  8  latched first instruction byte; feeds decoder
longoffs  out  8  latched second byte; 8'h00 for one-byte instructions
dec_twobyte  in  1  decoder: instr has a second byte
dec_mem  in  1  decoder: instr performs a data access
dec_write  in  1  decoder: data access is a store
dec_halt  in  1  decoder: halt instruction
calc_addr  in  16  data address from address calculator
calc_pcout  in  16  next PC from address calculator
bus_addr  out  16  memory address
bus_req  out  1  access request, held until bus_ready
bus_we  out  1  store strobe; valid with bus_req
bus_rdata  in  8  read data; valid when bus_ready=1
bus_ready  in  1  access complete this cycle
retire  out  1  one-cycle pulse when the PC commits
halted  out  1  sequencer stopped
fault  out  1  stopped because of a bus timeout

Behaviour:
- rst_n is asynchronous and active-low. Asserting it mid-operation forces state FETCH0 immediately. Reset values: pc=RESET_PC, instr=0, longoffs=0, wait counter=0, and all outputs (bus_req, bus_we, retire, halted, fault) = 0.
- States: FETCH0, FETCH1, DECODE, EXEC, COMMIT, HALT.
- FETCH0:
  - bus_addr=pc, bus_req=1, bus_we=0.
  - On bus_ready: instr<=bus_rdata, longoffs<=0, go DECODE.
- DECODE: one cycle, no bus request; decoder outputs settle from instr.
  - dec_halt -> HALT.
  - else dec_twobyte -> FETCH1, and pc<=pc+1 (16-bit wrap: FFFF->0000).
  - else dec_mem -> EXEC.
  - else -> COMMIT.
- FETCH1:
  - bus_addr=pc, bus_req=1.
  - On bus_ready: longoffs<=bus_rdata; go EXEC if dec_mem, else COMMIT.
- EXEC:
  - bus_addr=calc_addr, bus_req=1, bus_we=dec_write.
  - Read data is not captured; the datapath samples bus_rdata directly.
  - On bus_ready -> COMMIT.
- COMMIT: pc<=calc_pcout, retire=1 for exactly this cycle, -> FETCH0.
- During EXEC and COMMIT, pc holds the address of the instruction's last byte. The calculator's +1/offset therefore applies from the last byte.
- HALT: holds every register, bus_req=0, halted=1. Only reset exits HALT.
- Bus rules:
  - bus_addr and bus_we are stable while bus_req=1.
  - bus_ready with bus_req=0 is ignored.
  - A bus_ready arriving in the same cycle a request is first raised completes that access; zero-wait memory gives one cycle per access.
- Timeout:
  - The wait counter clears when each access starts and increments every cycle bus_req=1 and bus_ready=0.
  - When it reaches BUS_TIMEOUT (and BUS_TIMEOUT != 0): go HALT, fault<=1, no commit, pc unchanged.
  - bus_ready in the expiry cycle wins; the access completes normally.
- Latency with zero-wait memory:
  - 1-byte non-memory instruction: 3 cycles (FETCH0, DECODE, COMMIT).
  - 2-byte memory instruction: 5 cycles.
- No retire pulse on halt or fault.

Decomposition:
- Shared package:
  - state enum (3-bit encoding: FETCH0=0, FETCH1=1, DECODE=2, EXEC=3, COMMIT=4, HALT=5).
  - RESET_PC default constant.
  - bus width constants (ADDR_W=16, DATA_W=8).
- One natural sub-module: bus_wait_timer. It holds the wait counter, clear/enable, and the expiry compare, parameterised by BUS_TIMEOUT.
- The FSM and PC/instr registers stay in the top level.

Test Plan:
- Reset to 16'h0000, zero-wait bus, 1-byte non-mem instr, calc_pcout=16'h0001 -> bus_addr 0000 in FETCH0; retire on 3rd cycle; pc=0001.
- 2-byte jump at pc=16'h0010, second byte 8'hF0, calc_pcout=16'h0005 -> FETCH1 bus_addr=0011; longoffs=F0; pc=0005 after commit; 4 cycles total.
- Store at pc=0x0020, calc_addr=16'hFF3A, ready delayed 3 cycles -> bus_req=1, bus_we=1, bus_addr=FF3A held stable 4 cycles; then COMMIT.
- 2-byte instr at pc=16'hFFFF -> FETCH1 bus_addr=0000 (wrap).
- BUS_TIMEOUT=4, bus_ready never asserted in FETCH0 -> halted=1, fault=1 after 4 wait cycles; pc unchanged; no retire. Reset clears fault.
- Halt instr -> halted=1 with fault=0; bus_req stays 0 for 20 cycles. rst_n pulse mid-EXEC -> outputs reset immediately and fetch restarts at RESET_PC.
